// File: rtl/serial_read_buffer.sv
`timescale 1ns/1ps
// serial_read_buffer: serial-to-parallel capture buffer.
// Samples data_in on each read_sig strobe while capturing, assembles BUF_SIZE
// bits and publishes the finished word on data_out with done_sig high.
// Ports:
//   sys_clk  - system clock, rising edge
//   rst      - asynchronous active-low reset
//   start    - one-cycle request to begin a capture (honoured only when idle)
//   read_sig - one-cycle sample strobe (edge-detected bus clock)
//   data_in  - serial data line
//   data_out - last completed word (holding register)
//   done_sig - high when idle/complete, low while a capture is in progress
module serial_read_buffer #(
   parameter int unsigned BUF_SIZE  = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                sys_clk,
   input  logic                rst,
   input  logic                start,
   input  logic                read_sig,
   input  logic                data_in,
   output logic [BUF_SIZE-1:0] data_out,
   output logic                done_sig
);

   localparam int unsigned     CNT_W    = $clog2(BUF_SIZE + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BUF_SIZE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [BUF_SIZE-1:0] r_shift;
   logic [BUF_SIZE-1:0] w_shift_nxt;
   logic [BUF_SIZE-1:0] w_shift_in;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [BUF_SIZE-1:0] r_data;
   logic [BUF_SIZE-1:0] w_data_nxt;
   logic                r_done;
   logic                w_done_nxt;

   // Shift direction decides where the first received bit ends up.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_shift_in = {r_shift[BUF_SIZE-2:0], data_in};
      end else begin : g_lsb_first
         assign w_shift_in = {data_in, r_shift[BUF_SIZE-1:1]};
      end
   endgenerate

   // State and datapath registers.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_done  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_cnt   <= w_cnt_nxt;
         r_data  <= w_data_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = r_data;
      w_done_nxt  = r_done;

      case (r_state)
         ST_IDLE: begin
            // Strobes are dropped here, including one coincident with start.
            w_done_nxt = 1'b1;
            if (start) begin
               w_state_nxt = ST_READ;
               w_shift_nxt = '0;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b0;
            end
         end
         ST_READ: begin
            // start is ignored: no restart mid-word.
            w_done_nxt = 1'b0;
            if (read_sig) begin
               w_shift_nxt = w_shift_in;
               w_cnt_nxt   = r_cnt + CNT_W'(1);
               if (r_cnt == LAST_CNT) begin
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // Publish the whole word at once so partials never show.
            w_data_nxt  = r_shift;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
         end
      endcase
   end

   assign data_out = r_data;
   assign done_sig = r_done;

endmodule

// File: tb/tb_serial_read_buffer.sv
`timescale 1ns/1ps
// tb_serial_read_buffer: directed checks of serial_read_buffer in both bit orders.
module tb_serial_read_buffer;

   logic       sys_clk;
   logic       rst;
   logic       start_m, read_m, din_m;
   logic [7:0] dout_m;
   logic       done_m;
   logic       start_l, read_l, din_l;
   logic [7:0] dout_l;
   logic       done_l;

   int n_checks;
   int n_pass;

   serial_read_buffer #(.BUF_SIZE(8), .MSB_FIRST(1'b1)) dut (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .start    (start_m),
      .read_sig (read_m),
      .data_in  (din_m),
      .data_out (dout_m),
      .done_sig (done_m)
   );

   serial_read_buffer #(.BUF_SIZE(8), .MSB_FIRST(1'b0)) dut_lsb (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .start    (start_l),
      .read_sig (read_l),
      .data_in  (din_l),
      .data_out (dout_l),
      .done_sig (done_l)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // One strobe on the MSB-first instance, then idle until the next slot.
   task automatic strobe_m(input logic b, input int gap);
      din_m  = b;
      read_m = 1'b1;
      @(negedge sys_clk);
      read_m = 1'b0;
      repeat (gap - 1) @(negedge sys_clk);
   endtask

   task automatic pulse_start_m();
      start_m = 1'b1;
      @(negedge sys_clk);
      start_m = 1'b0;
   endtask

   logic [7:0] bits_a;
   logic [7:0] bits_b;
   logic [7:0] bits_c;
   logic [7:0] bits_l;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1;
      start_m = 1'b0; read_m = 1'b0; din_m = 1'b0;
      start_l = 1'b0; read_l = 1'b0; din_l = 1'b0;
      bits_a = 8'b1001_1100;
      bits_b = 8'b1110_0100;
      bits_c = 8'b0101_0101;
      bits_l = 8'b0011_1001;   // sent index 7 down to 0: 0,0,1,1,1,0,0,1

      // Asynchronous reset pulse 10..11 ns, checked before the 15 ns edge.
      #10 rst = 1'b0;
      #0.5;
      check("rst_dout", 32'(dout_m), 32'h00);
      check("rst_done", 32'(done_m), 32'h1);
      check("rst_done_lsb", 32'(done_l), 32'h1);
      #0.5 rst = 1'b1;
      @(negedge sys_clk);

      // Word 0x9C, one strobe per 8 cycles.
      pulse_start_m();
      check("start_done_low", 32'(done_m), 32'h0);
      for (int i = 7; i >= 0; i--) begin
         strobe_m(bits_a[i], (i == 0) ? 1 : 8);
         if (i == 4) check("partial_hidden", 32'(dout_m), 32'h00);
      end
      check("last_edge_dout", 32'(dout_m), 32'h00);
      check("last_edge_done", 32'(done_m), 32'h0);
      @(negedge sys_clk);
      check("w1_dout", 32'(dout_m), 32'h9C);
      check("w1_done", 32'(done_m), 32'h1);

      // Word 0xE4 aborted by reset after the third strobe.
      repeat (3) @(negedge sys_clk);
      pulse_start_m();
      for (int i = 7; i >= 5; i--) strobe_m(bits_b[i], 8);
      check("abort_busy", 32'(done_m), 32'h0);
      #2 rst = 1'b0;
      #1;
      check("abort_rst_dout", 32'(dout_m), 32'h00);
      check("abort_rst_done", 32'(done_m), 32'h1);
      rst = 1'b1;
      @(negedge sys_clk);
      for (int i = 4; i >= 0; i--) strobe_m(bits_b[i], 8);
      @(negedge sys_clk);
      check("abort_idle_dout", 32'(dout_m), 32'h00);
      check("abort_idle_done", 32'(done_m), 32'h1);

      // Full 0xE4 with a start issued mid-word.
      pulse_start_m();
      for (int i = 7; i >= 0; i--) begin
         strobe_m(bits_b[i], (i == 0) ? 1 : 8);
         if (i == 4) begin
            pulse_start_m();
            check("midstart_busy", 32'(done_m), 32'h0);
         end
      end
      check("w2_pre_dout", 32'(dout_m), 32'h00);
      @(negedge sys_clk);
      check("w2_dout", 32'(dout_m), 32'hE4);
      check("w2_done", 32'(done_m), 32'h1);

      // Strobes while idle are dropped.
      for (int i = 0; i < 4; i++) strobe_m(1'b1, 2);
      check("idle_strobe_dout", 32'(dout_m), 32'hE4);
      check("idle_strobe_done", 32'(done_m), 32'h1);

      // start coincident with a strobe: that strobe is not counted.
      start_m = 1'b1; read_m = 1'b1; din_m = 1'b1;
      @(negedge sys_clk);
      start_m = 1'b0; read_m = 1'b0;
      check("coinc_busy", 32'(done_m), 32'h0);
      for (int i = 7; i >= 1; i--) strobe_m(bits_c[i], 3);
      check("coinc_7_done", 32'(done_m), 32'h0);
      check("coinc_7_dout", 32'(dout_m), 32'hE4);
      strobe_m(bits_c[0], 1);
      check("coinc_pre_dout", 32'(dout_m), 32'hE4);
      @(negedge sys_clk);
      check("w3_dout", 32'(dout_m), 32'h55);
      check("w3_done", 32'(done_m), 32'h1);

      // LSB-first instance with back-to-back strobes.
      start_l = 1'b1;
      @(negedge sys_clk);
      start_l = 1'b0;
      check("lsb_start_done", 32'(done_l), 32'h0);
      for (int i = 7; i >= 0; i--) begin
         din_l  = bits_l[i];
         read_l = 1'b1;
         @(negedge sys_clk);
      end
      read_l = 1'b0;
      check("lsb_pre_dout", 32'(dout_l), 32'h00);
      check("lsb_pre_done", 32'(done_l), 32'h0);
      @(negedge sys_clk);
      check("lsb_dout", 32'(dout_l), 32'h9C);
      check("lsb_done", 32'(done_l), 32'h1);
      check("msb_untouched", 32'(dout_m), 32'h55);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
